// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin mux arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until granted; the owner releases with done or by dropping req.
//
// Signals:
//   req   [3:0]  request per requester, req[i] selects mux input I(i+1)
//   done  [3:0]  one-cycle release strobe; only the current owner's bit matters
//   grant [3:0]  one-hot grant, zero when nobody owns the mux
//   sel1, sel2   mux select lines S1/S2
//   busy         high while a grant is active
//   timeout      one-cycle pulse when a grant is revoked for holding too long
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       sel1;
  logic       sel2;
  logic       busy;
  logic       timeout;

  // Requester side.
  modport master (
    output req,
    output done,
    input  grant,
    input  sel1,
    input  sel2,
    input  busy,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output grant,
    output sel1,
    output sel2,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters; drives mux S1/S2 directly.
// Latency: one clock from a request seen in IDLE to a registered grant; 2-cycle owner turnaround.
// Backpressure: none; waiting requesters keep req high and are served in rotating order.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears all outputs immediately
//   bus   mux4_rr_arbiter_if.slave (req/done in; grant/sel1/sel2/busy/timeout out)
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Last hold value at which the owner may still keep the grant.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  // last_q doubles as the current owner while in GRANT.
  logic [1:0]        last_q,  last_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q,   sel_d;
  logic              timeout_q, timeout_d;

  logic [1:0]        winner;
  logic              found;
  logic [1:0]        idx;
  logic              rel_done;
  logic              rel_req;
  logic              hold_hit;

  // Rotating priority: scan last+1, last+2, last+3, last (k=4 wraps to last),
  // so the previous owner is considered last.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign rel_done = bus.done[last_q];
  assign rel_req  = ~bus.req[last_q];
  assign hold_hit = (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_d    = last_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          hold_d  = '0;
          last_d  = winner;
        end
      end

      GRANT: begin
        if (rel_done || rel_req || hold_hit) begin
          state_d   = GAP;
          grant_d   = 4'b0000;
          hold_d    = '0;
          // A voluntary release on the same edge takes precedence over the timeout.
          timeout_d = hold_hit && !rel_done && !rel_req;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= 2'd3;
      grant_q   <= 4'b0000;
      sel_q     <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel1    = sel_q[1];
  assign bus.sel2    = sel_q[0];
  assign bus.busy    = (state_q == GRANT);
  assign bus.timeout = timeout_q;

endmodule
